// File: rtl/tqvp_reed_solomon_encoder_pkg.sv
// Shared definitions for the Reed-Solomon encoder.
// Contents: symbol width, correction capacity, the parity capacity derived
// from it, the control state encoding, and the parity-count clamp helper.
package tqvp_reed_solomon_encoder_pkg;
   localparam int SYM_W      = 8;
   localparam int MAX_ERRORS = 16;
   localparam int NPAR       = 2 * MAX_ERRORS;

   typedef enum logic [1:0] {ST_IDLE, ST_GEN, ST_MSG, ST_PAR} state_e;

   // Parity count must be even and within 2..NPAR.
   function automatic logic [5:0] clamp_nroots(input logic [5:0] n);
      logic [5:0] even;
      even = {n[5:1], 1'b0};
      if (even == 6'd0) return 6'd2;
      if (even > 6'(NPAR)) return 6'(NPAR);
      return even;
   endfunction
endpackage

// File: rtl/tqvp_reed_solomon_encoder_if.sv
// Bus bundle for the Reed-Solomon encoder.
// Groups: runtime configuration (cfg_*), start strobe, message input stream
// (in_*), codeword output stream (out_*), and status (busy, done, overflow).
// master = the side driving config/message and sinking the codeword;
// slave  = the encoder.
interface tqvp_reed_solomon_encoder_if;
   import tqvp_reed_solomon_encoder_pkg::*;

   logic [SYM_W:0]   cfg_irreducible;
   logic [SYM_W-1:0] cfg_alpha;
   logic [SYM_W-1:0] cfg_first_root;
   logic [5:0]       cfg_nroots;
   logic             start;
   logic [SYM_W-1:0] in_data;
   logic             in_valid;
   logic             in_last;
   logic             in_ready;
   logic [SYM_W-1:0] out_data;
   logic             out_valid;
   logic             out_last;
   logic             out_ready;
   logic             busy;
   logic             done;
   logic             overflow;

   modport master (
      output cfg_irreducible, cfg_alpha, cfg_first_root, cfg_nroots, start,
             in_data, in_valid, in_last, out_ready,
      input  in_ready, out_data, out_valid, out_last, busy, done, overflow
   );

   modport slave (
      input  cfg_irreducible, cfg_alpha, cfg_first_root, cfg_nroots, start,
             in_data, in_valid, in_last, out_ready,
      output in_ready, out_data, out_valid, out_last, busy, done, overflow
   );
endinterface

// File: rtl/tqvp_reed_solomon_encoder_gf_mul.sv
// Combinational GF(2^8) multiplier with a programmable field polynomial.
// Ports: a_i, b_i  operands
//        poly_i    field polynomial (bit 8 set)
//        p_o       product a_i * b_i mod poly_i
module tqvp_reed_solomon_encoder_gf_mul
   import tqvp_reed_solomon_encoder_pkg::*;
(
   input  logic [SYM_W-1:0] a_i,
   input  logic [SYM_W-1:0] b_i,
   input  logic [SYM_W:0]   poly_i,
   output logic [SYM_W-1:0] p_o
);
   logic [SYM_W-1:0] acc;
   logic [SYM_W-1:0] aa;
   logic [SYM_W:0]   sh;

   // Shift-and-add: aa walks through a*x^i, reduced after every shift.
   always_comb begin
      acc = '0;
      aa  = a_i;
      sh  = '0;
      for (int i = 0; i < SYM_W; i++) begin
         if (b_i[i]) acc = acc ^ aa;
         sh = {aa, 1'b0};
         if (sh[SYM_W]) sh = sh ^ poly_i;
         aa = sh[SYM_W-1:0];
      end
      p_o = acc;
   end
endmodule

// File: rtl/tqvp_reed_solomon_encoder.sv
// Systematic Reed-Solomon encoder over GF(2^8).
// On start it latches the configuration and builds g(x) one root per cycle,
// then passes message symbols straight through while dividing by g(x) in an
// LFSR, then emits the nroots parity symbols, highest degree first.
// Ports: clk, rst_n (async, active low)
//        enc  slave side of the encoder bus (config, start, in/out streams,
//             busy/done/overflow status)
module tqvp_reed_solomon_encoder
   import tqvp_reed_solomon_encoder_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst_n,
   tqvp_reed_solomon_encoder_if.slave   enc
);
   state_e           state_q;
   logic [SYM_W:0]   poly_q;
   logic [SYM_W-1:0] alpha_q;
   logic [SYM_W-1:0] root_q;
   logic [5:0]       nroots_q;
   logic [5:0]       gen_cnt_q;
   logic [5:0]       par_cnt_q;
   logic [7:0]       sym_cnt_q;
   logic             done_q;
   logic             overflow_q;

   logic [SYM_W-1:0] g_q  [NPAR];
   logic [SYM_W-1:0] g_d  [NPAR];
   logic [SYM_W-1:0] p_q  [NPAR];
   logic [SYM_W-1:0] p_d  [NPAR];
   logic [SYM_W-1:0] prod [NPAR];

   logic [SYM_W-1:0] top_sym;
   logic [SYM_W-1:0] fb;
   logic [SYM_W-1:0] mul_a;
   logic [SYM_W-1:0] root_next;
   logic [4:0]       top_idx;
   logic             accept;
   logic             par_pop;

   assign top_idx = 5'(nroots_q - 6'd1);
   assign top_sym = p_q[top_idx];
   assign fb      = enc.in_data ^ top_sym;
   assign accept  = (state_q == ST_MSG) && enc.in_valid && enc.out_ready;
   assign par_pop = (state_q == ST_PAR) && enc.out_ready;

   // The coefficient multipliers serve both phases: the current root while
   // building g(x), the LFSR feedback symbol while dividing.
   assign mul_a = (state_q == ST_GEN) ? root_q : fb;

   genvar gi;
   generate
      for (gi = 0; gi < NPAR; gi++) begin : g_coef_mul
         tqvp_reed_solomon_encoder_gf_mul u_mul (
            .a_i    (mul_a),
            .b_i    (g_q[gi]),
            .poly_i (poly_q),
            .p_o    (prod[gi])
         );
      end
   endgenerate

   tqvp_reed_solomon_encoder_gf_mul u_root_mul (
      .a_i    (root_q),
      .b_i    (alpha_q),
      .poly_i (poly_q),
      .p_o    (root_next)
   );

   always_comb begin
      g_d = g_q;
      p_d = p_q;
      case (state_q)
         ST_IDLE: begin
            if (enc.start) begin
               for (int j = 0; j < NPAR; j++) begin
                  g_d[j] = '0;
                  p_d[j] = '0;
               end
               g_d[0] = 8'h01;
            end
         end
         ST_GEN: begin
            // g(x) <- g(x) * (x + root)
            g_d[0] = prod[0];
            for (int j = 1; j < NPAR; j++) g_d[j] = g_q[j-1] ^ prod[j];
         end
         ST_MSG: begin
            if (accept) begin
               p_d[0] = prod[0];
               for (int j = 1; j < NPAR; j++) p_d[j] = p_q[j-1] ^ prod[j];
               // Stages above the active length hold the monic 1 of g(x); keep them clear.
               for (int j = 0; j < NPAR; j++)
                  if (6'(j) >= nroots_q) p_d[j] = '0;
            end
         end
         ST_PAR: begin
            if (par_pop) begin
               if (par_cnt_q == 6'd1) begin
                  for (int j = 0; j < NPAR; j++) p_d[j] = '0;
               end else begin
                  p_d[0] = '0;
                  for (int j = 1; j < NPAR; j++) p_d[j] = p_q[j-1];
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         poly_q     <= '0;
         alpha_q    <= '0;
         root_q     <= '0;
         nroots_q   <= 6'd2;
         gen_cnt_q  <= '0;
         par_cnt_q  <= '0;
         sym_cnt_q  <= '0;
         done_q     <= 1'b0;
         overflow_q <= 1'b0;
         for (int j = 0; j < NPAR; j++) begin
            g_q[j] <= '0;
            p_q[j] <= '0;
         end
      end else begin
         g_q    <= g_d;
         p_q    <= p_d;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (enc.start) begin
                  poly_q     <= enc.cfg_irreducible;
                  alpha_q    <= enc.cfg_alpha;
                  root_q     <= enc.cfg_first_root;
                  nroots_q   <= clamp_nroots(enc.cfg_nroots);
                  gen_cnt_q  <= '0;
                  overflow_q <= 1'b0;
                  state_q    <= ST_GEN;
               end
            end
            ST_GEN: begin
               root_q <= root_next;
               if (gen_cnt_q == nroots_q - 6'd1) begin
                  sym_cnt_q <= '0;
                  state_q   <= ST_MSG;
               end else begin
                  gen_cnt_q <= gen_cnt_q + 6'd1;
               end
            end
            ST_MSG: begin
               if (accept) begin
                  sym_cnt_q <= sym_cnt_q + 8'd1;
                  // Codeword length is capped at 255 symbols.
                  if (enc.in_last || sym_cnt_q == 8'(8'd254 - {2'b00, nroots_q})) begin
                     overflow_q <= !enc.in_last;
                     par_cnt_q  <= nroots_q;
                     state_q    <= ST_PAR;
                  end
               end
            end
            ST_PAR: begin
               if (par_pop) begin
                  if (par_cnt_q == 6'd1) begin
                     done_q  <= 1'b1;
                     state_q <= ST_IDLE;
                  end else begin
                     par_cnt_q <= par_cnt_q - 6'd1;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign enc.in_ready  = (state_q == ST_MSG) && enc.out_ready;
   assign enc.out_valid = (state_q == ST_MSG) ? enc.in_valid : (state_q == ST_PAR);
   assign enc.out_data  = (state_q == ST_MSG) ? enc.in_data :
                          (state_q == ST_PAR) ? top_sym : '0;
   assign enc.out_last  = (state_q == ST_PAR) && (par_cnt_q == 6'd1);
   assign enc.busy      = (state_q != ST_IDLE);
   assign enc.done      = done_q;
   assign enc.overflow  = overflow_q;
endmodule

// File: tb/tb_tqvp_reed_solomon_encoder.sv
// Testbench for tqvp_reed_solomon_encoder: directed codewords checked against
// a polynomial-arithmetic model (generator product, long division, syndromes).
module tb_tqvp_reed_solomon_encoder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   tqvp_reed_solomon_encoder_if bus();

   tqvp_reed_solomon_encoder dut (
      .clk   (clk),
      .rst_n (rst_n),
      .enc   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int done_cnt = 0;
   int obs_base = 0;
   int last_acc_cyc = 0;
   bit rand_ready = 1'b0;
   bit hold_ready = 1'b1;
   logic [8:0] cur_poly;
   logic [7:0] cur_alpha;
   logic [7:0] cur_root;
   logic [7:0] msg_q[$];
   logic [7:0] exp_d[$];
   bit         exp_l[$];
   logic [7:0] obs_q[$];
   logic [7:0] ref_q[$];
   logic [7:0] m_g[33];
   logic [7:0] m_par[32];

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   // ---------------- model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b, input logic [8:0] poly);
      logic [15:0] acc;
      acc = '0;
      for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ (16'(a) << i);
      for (int i = 15; i >= 8; i--) if (acc[i]) acc = acc ^ (16'(poly) << (i - 8));
      return acc[7:0];
   endfunction

   function automatic int model_clamp(input int n);
      int e;
      e = n - (n % 2);
      if (e < 2) e = 2;
      if (e > 32) e = 32;
      return e;
   endfunction

   // g(x) = prod (x + root_i), coefficients low degree first
   task automatic model_gen(input int n);
      logic [7:0] nxt[33];
      logic [7:0] r;
      foreach (m_g[j]) m_g[j] = 8'h00;
      m_g[0] = 8'h01;
      r = cur_root;
      for (int i = 0; i < n; i++) begin
         nxt[0] = gmul(r, m_g[0], cur_poly);
         for (int j = 1; j < 33; j++) nxt[j] = m_g[j-1] ^ gmul(r, m_g[j], cur_poly);
         m_g = nxt;
         r = gmul(r, cur_alpha, cur_poly);
      end
   endtask

   // remainder of m(x)*x^n / g(x); m_par[0] is the highest-degree term
   task automatic model_parity(input int n);
      logic [7:0] wk[$];
      logic [7:0] c;
      int k;
      k = msg_q.size();
      wk = msg_q;
      for (int j = 0; j < n; j++) wk.push_back(8'h00);
      for (int i = 0; i < k; i++) begin
         c = wk[i];
         for (int j = 1; j <= n; j++) wk[i+j] = wk[i+j] ^ gmul(c, m_g[n-j], cur_poly);
      end
      for (int j = 0; j < n; j++) m_par[j] = wk[k+j];
   endtask

   function automatic int syndromes_nz(input int base, input int len, input int n);
      int nz;
      logic [7:0] x;
      logic [7:0] s;
      nz = 0;
      x = cur_root;
      for (int i = 0; i < n; i++) begin
         s = 8'h00;
         for (int t = 0; t < len; t++) s = gmul(s, x, cur_poly) ^ obs_q[base+t];
         if (s != 8'h00) nz++;
         x = gmul(x, cur_alpha, cur_poly);
      end
      return nz;
   endfunction

   // ---------------- background processes ----------------
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (bus.done) done_cnt <= done_cnt + 1;

   initial begin
      bus.out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : hold_ready;
      end
   end

   // Every output handshake is checked against the expected codeword stream.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) begin
         obs_q.push_back(bus.out_data);
         checks++;
         if (exp_d.size() == 0) begin
            failures++;
            $display("FAIL unexpected_out actual=0x%0h required=none", bus.out_data);
         end else begin
            checks--;
            chk("out_data", bus.out_data, exp_d.pop_front());
            chk("out_last", bus.out_last, exp_l.pop_front());
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic send(input logic [7:0] d, input bit last);
      bit ok;
      ok = 1'b0;
      bus.in_data = d;
      bus.in_valid = 1'b1;
      bus.in_last = last;
      for (int t = 0; t < 2000 && !ok; t++) begin
         @(negedge clk);
         ok = bus.in_ready;
      end
      if (!ok) chk("in_ready_timeout", ok, 1);
      @(posedge clk);
      #1;
      last_acc_cyc = cyc;
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
   endtask

   task automatic run_encode(input logic [5:0] ncfg, input bit with_last, input bit exp_ovf,
                             input bit check_lat, input bit disturb, input bit abort);
      int n, k, done_base, s_cyc, first_acc;
      bit seen;
      n = model_clamp(int'(ncfg));
      k = msg_q.size();
      model_gen(n);
      model_parity(n);
      foreach (msg_q[i]) begin
         exp_d.push_back(msg_q[i]);
         exp_l.push_back(1'b0);
      end
      for (int j = 0; j < n; j++) begin
         exp_d.push_back(m_par[j]);
         exp_l.push_back(j == n - 1);
      end
      obs_base = obs_q.size();
      done_base = done_cnt;
      first_acc = 0;
      bus.cfg_irreducible = cur_poly;
      bus.cfg_alpha = cur_alpha;
      bus.cfg_first_root = cur_root;
      bus.cfg_nroots = ncfg;
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      s_cyc = cyc;
      chk("overflow_cleared_on_start", bus.overflow, 0);
      chk("busy_after_start", bus.busy, 1);
      if (disturb) begin
         bus.cfg_alpha = ~cur_alpha;
         bus.cfg_first_root = 8'h55;
         bus.cfg_nroots = 6'd4;
         bus.start = 1'b1;
         @(posedge clk); #1 bus.start = 1'b0;
      end
      for (int i = 0; i < k; i++) begin
         send(msg_q[i], with_last && (i == k - 1));
         if (i == 0) first_acc = last_acc_cyc;
      end
      if (check_lat) chk("first_accept_latency", first_acc - s_cyc, n + 1);
      if (abort) begin
         hold_ready = 1'b0;
         repeat (3) @(posedge clk);
         @(negedge clk);
         chk("in_par_before_reset", {bus.busy, bus.out_valid, bus.in_ready}, 3'b110);
         #2 rst_n = 1'b0;
         #1 chk("outputs_after_reset",
                {bus.busy, bus.in_ready, bus.out_valid, bus.out_last, bus.done, bus.overflow, bus.out_data}, 0);
         exp_d.delete();
         exp_l.delete();
         repeat (2) @(posedge clk);
         #2 rst_n = 1'b1;
         hold_ready = 1'b1;
      end else begin
         seen = 1'b0;
         for (int t = 0; t < 4000 && !seen; t++) begin
            @(negedge clk);
            seen = bus.done;
         end
         chk("done_seen", seen, 1);
         @(negedge clk);
         chk("done_pulses", done_cnt - done_base, 1);
         chk("expected_drained", exp_d.size(), 0);
         chk("overflow_flag", bus.overflow, exp_ovf);
         chk("idle_after_done", bus.busy, 0);
      end
      bus.cfg_alpha = cur_alpha;
      bus.cfg_first_root = cur_root;
   endtask

   // ---------------- directed tests ----------------
   initial begin
      bus.cfg_irreducible = 9'h11D;
      bus.cfg_alpha = 8'h02;
      bus.cfg_first_root = 8'h01;
      bus.cfg_nroots = 6'd2;
      bus.start = 1'b0;
      bus.in_data = 8'h00;
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
      cur_poly = 9'h11D;
      cur_alpha = 8'h02;
      cur_root = 8'h01;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs",
          {bus.busy, bus.in_ready, bus.out_valid, bus.out_last, bus.done, bus.overflow, bus.out_data}, 0);
      rst_n = 1'b1;

      // Hand-computed values pinning the model
      chk("model_gmul", gmul(8'h80, 8'h02, 9'h11D), 8'h1D);
      model_gen(2);
      chk("model_g_n2", {m_g[2], m_g[1], m_g[0]}, 24'h010302);
      msg_q = '{8'h01};
      model_parity(2);
      chk("model_parity_n2", {m_par[0], m_par[1]}, 16'h0302);

      // Single-symbol message, nroots 2
      msg_q = '{8'h01};
      run_encode(6'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t1_count", obs_q.size() - obs_base, 3);
      chk("t1_codeword", {obs_q[obs_base], obs_q[obs_base+1], obs_q[obs_base+2]}, 24'h010302);

      // Ten zeros, with a start pulse and cfg change while busy
      msg_q.delete();
      repeat (10) msg_q.push_back(8'h00);
      run_encode(6'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("t2_count", obs_q.size() - obs_base, 12);
      chk("t2_parity_zero", {obs_q[obs_base+10], obs_q[obs_base+11]}, 0);

      // Full-length RS(255,223), unstalled, then stalled with same message
      msg_q.delete();
      repeat (223) msg_q.push_back(8'($urandom));
      run_encode(6'd32, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t3_count", obs_q.size() - obs_base, 255);
      chk("t3_syndromes_nonzero", syndromes_nz(obs_base, 255, 32), 0);
      ref_q.delete();
      for (int i = 0; i < 255; i++) ref_q.push_back(obs_q[obs_base+i]);
      rand_ready = 1'b1;
      run_encode(6'd32, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      begin
         int mism;
         mism = 0;
         for (int i = 0; i < 255; i++) if (obs_q[obs_base+i] !== ref_q[i]) mism++;
         chk("t3_stalled_matches_unstalled", mism, 0);
      end
      rand_ready = 1'b0;

      // nroots clamp: 0 -> 2, 5 -> 4
      msg_q = '{8'h01};
      run_encode(6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("clamp0_codeword", {obs_q[obs_base], obs_q[obs_base+1], obs_q[obs_base+2]}, 24'h010302);
      cur_poly = 9'h12B;
      cur_root = 8'h02;
      msg_q.delete();
      repeat (20) msg_q.push_back(8'($urandom));
      run_encode(6'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("clamp5_count", obs_q.size() - obs_base, 24);
      chk("clamp5_syndromes_nonzero", syndromes_nz(obs_base, 24, 4), 0);

      // Overflow: 253 symbols without in_last at nroots 2
      cur_poly = 9'h11D;
      cur_root = 8'h01;
      msg_q.delete();
      repeat (253) msg_q.push_back(8'($urandom));
      run_encode(6'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("ovf_count", obs_q.size() - obs_base, 255);
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("idle_in_ready_low", bus.in_ready, 0);
      bus.in_valid = 1'b0;

      // Reset mid-parity, then a clean encode
      msg_q.delete();
      repeat (6) msg_q.push_back(8'($urandom));
      run_encode(6'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      msg_q.delete();
      repeat (5) msg_q.push_back(8'($urandom));
      rand_ready = 1'b1;
      run_encode(6'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      rand_ready = 1'b0;
      chk("post_reset_count", obs_q.size() - obs_base, 9);
      chk("post_reset_syndromes_nonzero", syndromes_nz(obs_base, 9, 4), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
